// File: rtl/usr_pkg.sv
// Shared types and constants for the usr serial receive path.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package usr_pkg;

    // Default data bits per word.
    localparam int USR_DEF_WIDTH = 8;

    // Framing states of the deserialiser.
    typedef enum logic [1:0] {
        HUNT  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } deser_state_t;

    // Bit-counter width: must hold 0..WIDTH, since the parity phase parks at WIDTH.
    function automatic int cnt_w(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/usr_deser_hold.sv
// One-entry holding register between the word assembler and the parallel consumer.
// Latency: word visible on q/q_valid one cycle after load_vld.
// Backpressure: q_ready stalls; a load that finds the entry full and not draining is dropped and sets overrun.
//
// Ports:
//   clk, clr_n       clock, async active-low reset
//   load_vld/dat     completed word from the assembler (single-cycle pulse)
//   q_ready          consumer accepts q when q_valid & q_ready
//   ovr_clr          synchronous clear of the sticky overrun flag
//   q, q_valid       held word and full flag
//   overrun          sticky: a completed word was dropped
module usr_deser_hold #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_vld,
    input  logic [WIDTH-1:0] load_dat,
    input  logic             q_ready,
    input  logic             ovr_clr,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    output logic             overrun
);

    logic [WIDTH-1:0] q_q, q_d;
    logic             q_valid_q, q_valid_d;
    logic             overrun_q, overrun_d;
    logic             accept;

    always_comb begin
        // A load is taken if the entry is empty or is being drained in the same cycle.
        accept    = load_vld && (!q_valid_q || q_ready);
        q_d       = q_q;
        q_valid_d = q_valid_q;
        overrun_d = overrun_q;

        if (accept) begin
            q_d       = load_dat;
            q_valid_d = 1'b1;
        end else if (q_valid_q && q_ready) begin
            q_valid_d = 1'b0;
        end

        // A new drop wins over a simultaneous clear.
        if (load_vld && !accept) begin
            overrun_d = 1'b1;
        end else if (ovr_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            q_q       <= '0;
            q_valid_q <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            overrun_q <= overrun_d;
        end
    end

    assign q       = q_q;
    assign q_valid = q_valid_q;
    assign overrun = overrun_q;

endmodule

// File: rtl/usr_deser.sv
// LSB-first serial-to-parallel receiver with sync-marker framing; optional parity via USR_DESER_PARITY_EN.
// Latency: word on q/q_valid the cycle after the strobe carrying its last bit.
// Backpressure: one-entry hold register; a word completing while it is full and not draining is dropped (overrun).
//
// Ports:
//   clk, clr_n         clock, async active-low reset
//   data_in, sin_en    serial bit and its strobe
//   sync               with sin_en: this bit is bit 0 of a new word
//   q, q_valid, q_ready  parallel word handshake
//   overrun, ovr_clr   sticky drop flag and its clear (ovr_clr also clears parity_err)
//   busy               word partially assembled
//   parity_err         sticky even-parity mismatch (tied 0 unless USR_DESER_PARITY_EN)
module usr_deser
    import usr_pkg::*;
#(
    parameter int WIDTH = USR_DEF_WIDTH
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             data_in,
    input  logic             sin_en,
    input  logic             sync,
    output logic [WIDTH-1:0] q,
    output logic             q_valid,
    input  logic             q_ready,
    output logic             overrun,
    input  logic             ovr_clr,
    output logic             busy,
    output logic             parity_err
);

    localparam int              CW   = cnt_w(WIDTH);
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    deser_state_t     state_q, state_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] sr_q, sr_d;
    logic             busy_q, busy_d;
    logic [WIDTH-1:0] shifted;
    logic             word_done;
    logic [WIDTH-1:0] word_dat;
`ifdef USR_DESER_PARITY_EN
    logic             par_bad;
    logic             parity_err_q, parity_err_d;
`endif

    always_comb begin
        shifted   = {data_in, sr_q[WIDTH-1:1]};
        state_d   = state_q;
        count_d   = count_q;
        sr_d      = sr_q;
        word_done = 1'b0;
        word_dat  = sr_q;
`ifdef USR_DESER_PARITY_EN
        par_bad   = 1'b0;
`endif

        if (sin_en) begin
            if (sync) begin
                // Sync always reframes: drop any partial word and take this bit as bit 0.
                state_d = SHIFT;
                count_d = CW'(1);
                sr_d    = {data_in, {(WIDTH-1){1'b0}}};
            end else begin
                case (state_q)
                    HUNT: ;
                    SHIFT: begin
                        sr_d = shifted;
                        if (count_q == LAST) begin
`ifdef USR_DESER_PARITY_EN
                            state_d = PAR;
                            count_d = count_q + CW'(1);
`else
                            word_done = 1'b1;
                            word_dat  = shifted;
                            count_d   = '0;
`endif
                        end else begin
                            count_d = count_q + CW'(1);
                        end
                    end
`ifdef USR_DESER_PARITY_EN
                    PAR: begin
                        // Data is already aligned in sr; this strobe carries the parity bit.
                        word_done = 1'b1;
                        word_dat  = sr_q;
                        par_bad   = (^sr_q) ^ data_in;
                        state_d   = SHIFT;
                        count_d   = '0;
                    end
`endif
                    default: state_d = HUNT;
                endcase
            end
        end

        busy_d = (state_d != HUNT) && (count_d != '0);
`ifdef USR_DESER_PARITY_EN
        parity_err_d = parity_err_q;
        if (word_done && par_bad) begin
            parity_err_d = 1'b1;
        end else if (ovr_clr) begin
            parity_err_d = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q <= HUNT;
            count_q <= '0;
            sr_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            sr_q    <= sr_d;
            busy_q  <= busy_d;
        end
    end

`ifdef USR_DESER_PARITY_EN
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            parity_err_q <= 1'b0;
        end else begin
            parity_err_q <= parity_err_d;
        end
    end
    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign busy = busy_q;

    usr_deser_hold #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk      (clk),
        .clr_n    (clr_n),
        .load_vld (word_done),
        .load_dat (word_dat),
        .q_ready  (q_ready),
        .ovr_clr  (ovr_clr),
        .q        (q),
        .q_valid  (q_valid),
        .overrun  (overrun)
    );

endmodule
